// File: rtl/madd_arbiter_if.sv
// Request, MADD-side and response signals of the MADD arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface madd_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic                 EN;
    logic [NREQ-1:0]      REQ_VALID;
    logic [32*NREQ-1:0]   REQ_A;
    logic [32*NREQ-1:0]   REQ_B;
    logic [32*NREQ-1:0]   REQ_C;
    logic [NREQ-1:0]      REQ_READY;
    logic [31:0]          MADD_A;
    logic [31:0]          MADD_B;
    logic [31:0]          MADD_C;
    logic [31:0]          MADD_Z;
    logic                 RSP_VALID;
    logic [IDW-1:0]       RSP_ID;
    logic [31:0]          RSP_Z;
    logic                 BUSY;
    logic [15:0]          ISSUE_CNT;

    modport slave (
        input  EN, REQ_VALID, REQ_A, REQ_B, REQ_C, MADD_Z,
        output REQ_READY, MADD_A, MADD_B, MADD_C,
               RSP_VALID, RSP_ID, RSP_Z, BUSY, ISSUE_CNT
    );

    modport master (
        output EN, REQ_VALID, REQ_A, REQ_B, REQ_C, MADD_Z,
        input  REQ_READY, MADD_A, MADD_B, MADD_C,
               RSP_VALID, RSP_ID, RSP_Z, BUSY, ISSUE_CNT
    );
endinterface

// File: rtl/madd_arbiter.sv
// Round-robin arbiter sharing one pipelined MADD unit (Z = A*B + C) between
// NREQ requesters; results come back tagged with the owning requester ID.
module madd_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int LATENCY = 2
) (
    input  logic           CLK,
    input  logic           RST,
    madd_arbiter_if.slave  bus
);
    localparam int DATA_W = 32;

    logic [IDW-1:0]           ptr;
    logic                     grant_found;
    logic [IDW-1:0]           grant_id;
    logic                     issue;
    logic [NREQ-1:0]          ready;
    logic signed [DATA_W-1:0] sel_a;
    logic signed [DATA_W-1:0] sel_b;
    logic signed [DATA_W-1:0] sel_c;

    logic signed [DATA_W-1:0] madd_a_p0;
    logic signed [DATA_W-1:0] madd_b_p0;
    logic signed [DATA_W-1:0] c_hold_p0;
    logic signed [DATA_W-1:0] madd_c_p1;

    logic [LATENCY-1:0]       tag_vld;
    logic [IDW-1:0]           tag_id [LATENCY];

    logic                     rsp_vld;
    logic [IDW-1:0]           rsp_id;
    logic signed [DATA_W-1:0] rsp_z;
    logic [15:0]              issue_cnt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
        return (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
    endfunction

    // Search upward from the pointer, wrapping at NREQ-1, for the first valid request.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!grant_found && bus.REQ_VALID[idx]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    assign issue = bus.EN & grant_found;

    always_comb begin
        ready = '0;
        sel_a = '0;
        sel_b = '0;
        sel_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                ready[i] = issue;
                sel_a    = signed'(bus.REQ_A[DATA_W*i +: DATA_W]);
                sel_b    = signed'(bus.REQ_B[DATA_W*i +: DATA_W]);
                sel_c    = signed'(bus.REQ_C[DATA_W*i +: DATA_W]);
            end
        end
    end

    // Stage 0: grant edge; A/B go straight to the MADD, C waits a cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr       <= '0;
            issue_cnt <= '0;
            madd_a_p0 <= '0;
            madd_b_p0 <= '0;
            c_hold_p0 <= '0;
        end else if (issue) begin
            ptr       <= next_ptr(grant_id);
            issue_cnt <= sat_inc16(issue_cnt);
            madd_a_p0 <= sel_a;
            madd_b_p0 <= sel_b;
            c_hold_p0 <= sel_c;
        end
    end

    // Stage 1: C reaches the MADD one edge after its A/B; only real issues update it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            madd_c_p1 <= '0;
        end else if (tag_vld[0]) begin
            madd_c_p1 <= c_hold_p0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tag_vld <= '0;
        end else begin
            tag_vld <= {tag_vld[LATENCY-2:0], issue};
        end
    end

    always_ff @(posedge CLK) begin
        tag_id[0] <= grant_id;
        for (int s = 1; s < LATENCY; s++) begin
            tag_id[s] <= tag_id[s-1];
        end
    end

    // Stage LATENCY: capture the MADD result for the op in the last tag slot.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rsp_vld <= 1'b0;
            rsp_id  <= '0;
            rsp_z   <= '0;
        end else if (tag_vld[LATENCY-1]) begin
            rsp_vld <= 1'b1;
            rsp_id  <= tag_id[LATENCY-1];
            rsp_z   <= signed'(bus.MADD_Z);
        end else begin
            rsp_vld <= 1'b0;
        end
    end

    assign bus.REQ_READY = ready;
    assign bus.MADD_A    = madd_a_p0;
    assign bus.MADD_B    = madd_b_p0;
    assign bus.MADD_C    = madd_c_p1;
    assign bus.RSP_VALID = rsp_vld;
    assign bus.RSP_ID    = rsp_id;
    assign bus.RSP_Z     = rsp_z;
    assign bus.BUSY      = (|tag_vld) | rsp_vld;
    assign bus.ISSUE_CNT = issue_cnt;
endmodule

// File: tb/tb_madd_arbiter.sv
// Randomized and directed bench for madd_arbiter with a queue-based scoreboard
// and a two-stage MADD model (product on cycle 1, C added on cycle 2).
module tb_madd_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct {
        int          id;
        logic [31:0] z;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   m_ptr = 0;
    int   m_cnt = 0;
    logic [NREQ-1:0] hs_mask = '0;
    logic [31:0] prod = '0;

    madd_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    madd_arbiter #(.NREQ(NREQ), .IDW(IDW), .LATENCY(2)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External MADD: A*B registered on the first edge, C added combinationally after.
    always @(posedge clk) prod <= bus.MADD_A * bus.MADD_B;
    assign bus.MADD_Z = prod + bus.MADD_C;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rnd32();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h7FFF_FFFF;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h0000_0000;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        bus.REQ_A[32*i +: 32] = a;
        bus.REQ_B[32*i +: 32] = b;
        bus.REQ_C[32*i +: 32] = c;
    endtask

    // Scoreboard/reference: evaluated mid-cycle, predicts the coming edge.
    initial begin
        int          pick;
        logic [NREQ-1:0] exp_rdy;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                m_ptr   = 0;
                m_cnt   = 0;
                hs_mask = '0;
            end else begin
                chk("busy", 32'(bus.BUSY), 32'(q.size() != 0));
                if (q.size() != 0 && q[0].due == cyc) begin
                    chk("rsp_valid", 32'(bus.RSP_VALID), 32'd1);
                    chk("rsp_id", 32'(bus.RSP_ID), 32'(q[0].id));
                    chk("rsp_z", bus.RSP_Z, q[0].z);
                    void'(q.pop_front());
                end else begin
                    chk("rsp_valid_idle", 32'(bus.RSP_VALID), 32'd0);
                end
                chk("issue_cnt", 32'(bus.ISSUE_CNT), 32'(m_cnt));
                pick    = rr_pick(bus.REQ_VALID, m_ptr);
                exp_rdy = '0;
                if (bus.EN && pick >= 0) begin
                    exp_rdy[pick] = 1'b1;
                    e.id  = pick;
                    e.z   = bus.REQ_A[32*pick +: 32] * bus.REQ_B[32*pick +: 32]
                          + bus.REQ_C[32*pick +: 32];
                    e.due = cyc + 3;
                    q.push_back(e);
                    m_ptr = (pick + 1) % NREQ;
                    if (m_cnt < 65535) m_cnt++;
                end
                hs_mask = exp_rdy;
                chk("req_ready", 32'(bus.REQ_READY), 32'(exp_rdy));
            end
        end
    end

    task automatic single_op(input int id, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [31:0] z);
        bus.REQ_VALID[id] = 1'b1;
        set_ops(id, a, b, c);
        @(posedge clk); #1;
        bus.REQ_VALID[id] = 1'b0;
        chk("single_madd_a", bus.MADD_A, a);
        chk("single_madd_b", bus.MADD_B, b);
        @(posedge clk); #1;
        chk("single_madd_c", bus.MADD_C, c);
        @(posedge clk); #1;
        chk("single_rsp_valid", 32'(bus.RSP_VALID), 32'd1);
        chk("single_rsp_id", 32'(bus.RSP_ID), 32'(id));
        chk("single_rsp_z", bus.RSP_Z, z);
    endtask

    task automatic drain();
        int n;
        bus.REQ_VALID = '0;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, required 0", q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [NREQ-1:0] exp_oh;
        bus.EN        = 1'b0;
        bus.REQ_VALID = '0;
        bus.REQ_A     = '0;
        bus.REQ_B     = '0;
        bus.REQ_C     = '0;
        #1;
        chk("rst_madd_a", bus.MADD_A, 32'd0);
        chk("rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_issue_cnt", 32'(bus.ISSUE_CNT), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        bus.EN = 1'b1;

        // Round-robin with all requesters held valid.
        for (int i = 0; i < NREQ; i++) set_ops(i, rnd32(), rnd32(), rnd32());
        bus.REQ_VALID = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_oh = 4'b0001 << (k % NREQ);
            chk("rr_grant", 32'(bus.REQ_READY), 32'(exp_oh));
            @(posedge clk); #1;
            set_ops(k % NREQ, rnd32(), rnd32(), rnd32());
        end
        bus.REQ_VALID = '0;
        @(negedge clk);
        chk("rr_issue_cnt", 32'(bus.ISSUE_CNT), 32'd8);
        drain();

        single_op(2, 32'd3, 32'd5, 32'd7, 32'h16);
        single_op(1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h8000_0001);
        drain();

        // Back-to-back from one requester.
        bus.REQ_VALID[0] = 1'b1;
        set_ops(0, 32'd2, 32'd3, 32'd1);
        @(posedge clk); #1;
        set_ops(0, 32'd4, 32'd5, 32'd6);
        @(posedge clk); #1;
        bus.REQ_VALID[0] = 1'b0;
        @(posedge clk); #1;
        chk("b2b_first_valid", 32'(bus.RSP_VALID), 32'd1);
        chk("b2b_first_z", bus.RSP_Z, 32'd7);
        @(posedge clk); #1;
        chk("b2b_second_valid", 32'(bus.RSP_VALID), 32'd1);
        chk("b2b_second_z", bus.RSP_Z, 32'd26);
        drain();

        // EN gating with an op already in flight.
        bus.REQ_VALID[3] = 1'b1;
        set_ops(3, 32'd11, 32'd13, 32'd17);
        @(posedge clk); #1;
        bus.EN        = 1'b0;
        bus.REQ_VALID = '1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("en_low_ready", 32'(bus.REQ_READY), 32'd0);
            @(posedge clk); #1;
        end
        bus.EN = 1'b1;
        @(negedge clk);
        chk("en_resume_ready", 32'(bus.REQ_READY), 32'd1);
        @(posedge clk); #1;
        drain();

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (hs_mask[i]) begin
                    if ($urandom_range(0, 1) == 0) bus.REQ_VALID[i] = 1'b0;
                    else set_ops(i, rnd32(), rnd32(), rnd32());
                end else if (!bus.REQ_VALID[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        bus.REQ_VALID[i] = 1'b1;
                        set_ops(i, rnd32(), rnd32(), rnd32());
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    bus.REQ_VALID[i] = 1'b0;
                end
            end
            bus.EN = ($urandom_range(0, 7) != 0);
            @(posedge clk); #1;
        end
        bus.EN = 1'b1;
        drain();

        // Reset with three ops in flight.
        bus.REQ_VALID[0] = 1'b1;
        set_ops(0, 32'd9, 32'd9, 32'd9);
        repeat (3) @(posedge clk);
        #1;
        bus.REQ_VALID = '0;
        rst = 1'b1;
        #1;
        chk("mid_rst_madd_a", bus.MADD_A, 32'd0);
        chk("mid_rst_madd_b", bus.MADD_B, 32'd0);
        chk("mid_rst_madd_c", bus.MADD_C, 32'd0);
        chk("mid_rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
        chk("mid_rst_rsp_id", 32'(bus.RSP_ID), 32'd0);
        chk("mid_rst_rsp_z", bus.RSP_Z, 32'd0);
        chk("mid_rst_issue_cnt", 32'(bus.ISSUE_CNT), 32'd0);
        chk("mid_rst_busy", 32'(bus.BUSY), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.REQ_VALID = '1;
        @(negedge clk);
        chk("post_rst_ptr", 32'(bus.REQ_READY), 32'd1);
        @(posedge clk); #1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/madd_arbiter.md
Name: madd_arbiter

Overview:
- Shares one pipelined MADD unit (Z = A*B + C, signed 32-bit, wrap modulo 2^32) between NREQ requesters.
- Round-robin grant, at most one issue per cycle.
- Delays C by one cycle to match the MADD C-on-second-cycle timing.
- Tracks in-flight operations with a tag pipeline and returns each result tagged with its requester ID.

Parameters:
- NREQ, 4: number of requesters (2..8).
- IDW, 2: requester ID width, equal to clog2(NREQ).
- LATENCY, 2: cycles from the issue edge to the MADD_Z sample edge (minimum 2).

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  issue enable; 0 blocks new grants, in-flight ops still complete.
- REQ_VALID  in  NREQ  per-requester request.
- REQ_A  in  32*NREQ  operand A, requester i at bits [32i+31:32i].
- REQ_B  in  32*NREQ  operand B, same packing.
- REQ_C  in  32*NREQ  addend C, same packing; sampled with A/B at grant.
- REQ_READY  out  NREQ  one-hot grant; combinational from REQ_VALID, EN and pointer.
- MADD_A  out  32  to MADD A.
- MADD_B  out  32  to MADD B.
- MADD_C  out  32  to MADD C; value is one cycle behind A/B.
- MADD_Z  in  32  from MADD Z.
- RSP_VALID  out  1  result valid, single-cycle pulse.
- RSP_ID  out  IDW  requester that owns RSP_Z.
- RSP_Z  out  32  result.
- BUSY  out  1  any operation in flight.
- ISSUE_CNT  out  16  saturating count of issued ops.

Behaviour:
- Reset (async, immediate):
  - MADD_A, MADD_B, MADD_C = 0; RSP_VALID = 0; RSP_ID = 0; RSP_Z = 0; ISSUE_CNT = 0.
  - RR pointer = 0; tag pipeline cleared; BUSY = 0.
  - Ops in flight at reset are discarded; no response is produced for them.
- Arbitration:
  - Grant goes to the first i with REQ_VALID[i]=1, searching from pointer upward and wrapping at NREQ-1 -> 0.
  - REQ_READY[i]=1 only for the winner, and only when EN=1.
  - Handshake completes on an edge with REQ_VALID[i] & REQ_READY[i]. Requester holds valid and operands until it sees ready.
  - After a grant to i, pointer = (i+1) mod NREQ. Pointer is unchanged when nothing is granted.
- Issue (grant edge t):
  - MADD_A and MADD_B register A_i and B_i; C_i goes to a holding register.
  - At edge t+1, MADD_C = held C.
  - Without a grant, MADD_A, MADD_B and MADD_C hold their prior values. The MADD output is ignored because no tag is valid.
- Tag pipeline:
  - LATENCY stages, each holding {valid, id}. Stage 0 is loaded at the grant edge with {1, i}, or {0, x} with no grant.
  - At edge t+LATENCY, when the last stage is valid: RSP_Z <= MADD_Z, RSP_ID <= id, RSP_VALID <= 1. Otherwise RSP_VALID <= 0.
  - RSP_VALID is high for exactly one cycle per op. Responses leave in issue order; there is no backpressure.
- Throughput:
  - One issue per cycle.
  - Back-to-back issues overlap in the pipeline. MADD_C for op n and MADD_A/B for op n+1 change on the same edge, as the MADD requires.
- BUSY = OR of tag valid bits plus RSP_VALID.
- ISSUE_CNT increments on each handshake and saturates at 0xFFFF.
- Boundaries:
  - EN falling mid-stream: pending tags drain and responses still arrive.
  - Single requester: granted every cycle while valid.
  - All NREQ valid: grants rotate 0,1,...,NREQ-1,0.
  - Requester drops valid before grant: no issue.

Test Plan:
- Reset mid-stream: issue 3 ops, assert RST for 1 cycle -> all outputs 0 immediately, no RSP_VALID for the flushed ops, BUSY=0.
- Single op: requester 2 sends A=3, B=5, C=7 at edge t -> RSP_VALID=1, RSP_ID=2, RSP_Z=0x16 after edge t+2; MADD_C=7 after edge t+1.
- Signed wrap: A=0xFFFFFFFF (-1), B=0x80000000, C=1 -> RSP_Z=0x80000001.
- Round-robin fairness: all 4 requesters held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; 8 responses with IDs in the same order; ISSUE_CNT=8.
- Back-to-back pipelining: requester 0 issues (2,3,1) then (4,5,6) on consecutive edges -> RSP_Z=7 then 26 on consecutive cycles, no bubble.
- EN gating: EN=0 with REQ_VALID=4'b1111 -> REQ_READY=0, no issue; earlier in-flight op still responds; on EN=1, grant resumes at the saved pointer.
